xs3_serial_adder: RTL and testbench

//  Digit-serial adder for multi-digit Excess-3 operands, LSD first, one digit pair per beat.

---
 rtl/xs3_serial_adder_if.sv | 27 ++
 rtl/xs3_serial_adder.sv | 79 +++++++
 tb/tb_xs3_serial_adder.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xs3_serial_adder_if.sv
// rtl/xs3_serial_adder_if.sv - digit-pair input stream and sum-digit output stream of the Excess-3 serial adder
interface xs3_serial_adder_if #(
    parameter int IDX_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_digit;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_carry;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_digit, out_idx, out_last, out_carry, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_digit, out_idx, out_last, out_carry, out_err
    );
endinterface

// File: rtl/xs3_serial_adder.sv
// rtl/xs3_serial_adder.sv - digit-serial Excess-3 adder, LSD first, carry rippling across beats
module xs3_serial_adder #(
    parameter int MAX_DIGITS = 16,
    parameter int IDX_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    xs3_serial_adder_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_DIGITS - 1);

    function automatic logic invalid_xs3(input logic [3:0] d);
        return (d < 4'd3) || (d > 4'd12);
    endfunction

    logic             carry_q;
    logic [IDX_W-1:0] count_q;
    logic             err_acc_q;

    logic             out_valid_q;
    logic [3:0]       out_digit_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             out_last_q;
    logic             out_carry_q;
    logic             out_err_q;

    logic             in_ready;
    logic             xfer;
    logic [4:0]       sum;
    logic [3:0]       digit_nxt;
    logic             err_nxt;
    logic             term;

    assign in_ready = ~out_valid_q | bus.out_ready;
    assign xfer     = bus.in_valid & in_ready;

    // Sum of two XS3 digits carries an excess of 6; a binary carry out means a decimal carry.
    always_comb begin
        sum       = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {4'b0000, carry_q};
        digit_nxt = sum[4] ? (sum[3:0] + 4'd3) : (sum[3:0] - 4'd3);
        err_nxt   = err_acc_q | invalid_xs3(bus.in_a) | invalid_xs3(bus.in_b);
        term      = bus.in_last | (count_q == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q     <= 1'b0;
            count_q     <= '0;
            err_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_digit_q <= 4'd3;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_digit_q <= digit_nxt;
            out_idx_q   <= count_q;
            out_err_q   <= err_nxt;
            out_last_q  <= term;
            out_carry_q <= term & sum[4];
            // A terminating beat clears the running state so the next beat is a fresh LSD.
            carry_q     <= term ? 1'b0 : sum[4];
            count_q     <= term ? '0 : count_q + 1'b1;
            err_acc_q   <= term ? 1'b0 : err_nxt;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_digit = out_digit_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_carry = out_carry_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_xs3_serial_adder.sv
// tb/tb_xs3_serial_adder.sv - self-checking bench for the Excess-3 serial adder
module tb_xs3_serial_adder;
    localparam int MAXD = 16;
    localparam int IW   = 4;

    typedef struct {
        logic [3:0]    digit;
        logic [IW-1:0] idx;
        logic          last;
        logic          carry;
        logic          err;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xs3_serial_adder_if #(.IDX_W(IW)) bus ();
    xs3_serial_adder #(.MAX_DIGITS(MAXD), .IDX_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    rec_t exp_q[$];
    rec_t obs_q[$];
    rec_t mon_e;
    bit   rnd_ready = 0;

    int   m_carry = 0;
    int   m_cnt   = 0;
    bit   m_err   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard: every accepted output digit is checked against the decimal model in order.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got digit=%h idx=%0d with nothing expected", bus.out_digit, bus.out_idx);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.out_digit, bus.out_idx, bus.out_last, bus.out_carry, bus.out_err} !==
                    {mon_e.digit, mon_e.idx, mon_e.last, mon_e.carry, mon_e.err}) begin
                    n_fail++;
                    $display("FAIL out_digit_seq: got d=%h i=%0d l=%b c=%b e=%b, expected d=%h i=%0d l=%b c=%b e=%b",
                             bus.out_digit, bus.out_idx, bus.out_last, bus.out_carry, bus.out_err,
                             mon_e.digit, mon_e.idx, mon_e.last, mon_e.carry, mon_e.err);
                end
            end
            obs_q.push_back('{bus.out_digit, bus.out_idx, bus.out_last, bus.out_carry, bus.out_err});
        end
    end

    // Decimal long addition: XS3 code minus 3 is the digit value; invalid codes just carry their offset.
    task automatic model_beat(input logic [3:0] a, input logic [3:0] b, input logic last);
        int   d;
        int   nc;
        rec_t e;
        d = (int'(a) - 3) + (int'(b) - 3) + m_carry;
        if (a < 3 || a > 12 || b < 3 || b > 12) m_err = 1;
        if (d >= 10) begin e.digit = 4'(d - 7); nc = 1; end
        else         begin e.digit = 4'(d + 3); nc = 0; end
        e.idx  = IW'(m_cnt);
        e.err  = m_err;
        e.last = last || (m_cnt == MAXD - 1);
        if (e.last) begin
            e.carry = nc[0]; m_carry = 0; m_cnt = 0; m_err = 0;
        end else begin
            e.carry = 1'b0; m_carry = nc; m_cnt++;
        end
        exp_q.push_back(e);
    endtask

    task automatic send_beat(input logic [3:0] a, input logic [3:0] b, input logic last);
        int guard;
        model_beat(a, b, last);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            n_chk++; n_fail++;
            $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, guard);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 500) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d digits still pending, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_carry = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_a = 4'd3; bus.in_b = 4'd3; bus.in_last = 0; bus.out_ready = 1;
        do_reset();
        @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.out_digit, bus.out_idx, bus.out_last, bus.out_carry, bus.out_err, bus.in_ready} !==
            {1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: v=%b d=%h i=%0d l=%b c=%b e=%b rdy=%b, required 0 3 0 0 0 0 1",
                     bus.out_valid, bus.out_digit, bus.out_idx, bus.out_last, bus.out_carry, bus.out_err, bus.in_ready);
        end
    endtask

    task automatic test_single_zero();
        @(posedge clk); #1;
        obs_q.delete();
        model_beat(4'd3, 4'd3, 1'b1);
        bus.in_valid = 1; bus.in_a = 4'd3; bus.in_b = 4'd3; bus.in_last = 1;
        @(posedge clk); #1;
        bus.in_valid = 0;
        @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.out_digit, bus.out_last, bus.out_carry} !== {1'b1, 4'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_latency: v=%b d=%h l=%b c=%b, required 1 3 1 0",
                     bus.out_valid, bus.out_digit, bus.out_last, bus.out_carry);
        end
        drain();
    endtask

    task automatic test_45_78();
        obs_q.delete();
        send_beat(4'h8, 4'hB, 1'b0);
        send_beat(4'h7, 4'hA, 1'b1);
        drain();
        n_chk++;
        if (obs_q.size() != 2 ||
            {obs_q[0].digit, obs_q[1].digit, obs_q[1].last, obs_q[1].carry} !== {4'd6, 4'd5, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sum_45_78: got %0d digits, required 2 with d=6,5 last carry=1", obs_q.size());
        end
    endtask

    task automatic test_9999_0001();
        obs_q.delete();
        send_beat(4'hC, 4'h4, 1'b0);
        for (int i = 0; i < 2; i++) send_beat(4'hC, 4'h3, 1'b0);
        send_beat(4'hC, 4'h3, 1'b1);
        drain();
        n_chk++;
        if (obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL sum_9999_count: got %0d digits, required 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if ({obs_q[i].digit, obs_q[i].last, obs_q[i].carry} !== {4'd3, (i == 3), (i == 3)}) begin
                    n_fail++;
                    $display("FAIL sum_9999_digit%0d: d=%h l=%b c=%b, required 3 %0d %0d",
                             i, obs_q[i].digit, obs_q[i].last, obs_q[i].carry, i == 3, i == 3);
                end
            end
        end
    endtask

    task automatic test_hold();
        rec_t snap;
        obs_q.delete();
        bus.out_ready = 0;
        send_beat(4'h9, 4'h8, 1'b0);
        fork
            send_beat(4'h5, 4'hA, 1'b0);
            begin
                @(negedge clk);
                snap = '{bus.out_digit, bus.out_idx, bus.out_last, bus.out_carry, bus.out_err};
                repeat (3) begin
                    @(negedge clk);
                    n_chk++;
                    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                        {bus.out_digit, bus.out_idx, bus.out_last, bus.out_carry, bus.out_err} !==
                        {snap.digit, snap.idx, snap.last, snap.carry, snap.err}) begin
                        n_fail++;
                        $display("FAIL hold_stable: rdy=%b v=%b d=%h i=%0d, required 0 1 %h %0d",
                                 bus.in_ready, bus.out_valid, bus.out_digit, bus.out_idx, snap.digit, snap.idx);
                    end
                end
                @(posedge clk); #1;
                bus.out_ready = 1;
            end
        join
        send_beat(4'h3, 4'h3, 1'b1);
        drain();
        n_chk++;
        if (obs_q.size() != 3) begin
            n_fail++;
            $display("FAIL hold_count: got %0d digits, required 3", obs_q.size());
        end
    endtask

    task automatic test_err();
        obs_q.delete();
        send_beat(4'hF, 4'h3, 1'b0);
        send_beat(4'h4, 4'h3, 1'b0);
        send_beat(4'h5, 4'h3, 1'b1);
        send_beat(4'h6, 4'h7, 1'b0);
        send_beat(4'h6, 4'h7, 1'b1);
        drain();
        n_chk++;
        if (obs_q.size() != 5 ||
            {obs_q[0].err, obs_q[1].err, obs_q[2].err, obs_q[3].err, obs_q[4].err} !== 5'b11100) begin
            n_fail++;
            $display("FAIL err_flag: got %0d digits, required 5 with err pattern 11100", obs_q.size());
        end
    endtask

    task automatic test_forced_end();
        obs_q.delete();
        for (int i = 0; i < MAXD; i++) send_beat(4'(3 + (i % 10)), 4'h7, 1'b0);
        send_beat(4'h4, 4'h4, 1'b0);
        send_beat(4'h4, 4'h4, 1'b1);
        drain();
        n_chk++;
        if (obs_q.size() != MAXD + 2 ||
            {obs_q[MAXD-2].last, obs_q[MAXD-1].last, obs_q[MAXD-1].idx, obs_q[MAXD].idx} !==
            {1'b0, 1'b1, 4'(MAXD - 1), 4'd0}) begin
            n_fail++;
            $display("FAIL forced_end: got %0d digits, required %0d with last at idx %0d", obs_q.size(), MAXD + 2, MAXD - 1);
        end
    endtask

    task automatic test_reset_mid_op();
        obs_q.delete();
        bus.out_ready = 0;
        send_beat(4'hC, 4'hC, 1'b0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        exp_q.delete();
        m_carry = 0; m_cnt = 0; m_err = 0;
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_valid: out_valid=%b, required 0", bus.out_valid);
        end
        bus.out_ready = 1;
        send_beat(4'h3, 4'h3, 1'b1);
        drain();
        n_chk++;
        if (obs_q.size() != 1 || {obs_q[0].digit, obs_q[0].idx, obs_q[0].carry} !== {4'd3, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_next: got %0d digits, required 1 digit=3 idx=0 carry=0", obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        bus.out_ready = 1;
        t0 = cyc;
        for (int op = 0; op < 3; op++)
            for (int i = 0; i < 3; i++)
                send_beat(4'($urandom_range(3, 12)), 4'($urandom_range(3, 12)), i == 2);
        n_chk++;
        if (cyc - t0 != 9) begin
            n_fail++;
            $display("FAIL back_to_back: took %0d cycles for 9 beats, required 9", cyc - t0);
        end
        drain();
    endtask

    task automatic test_random();
        int len;
        logic [3:0] a;
        logic [3:0] b;
        rnd_ready = 1;
        for (int op = 0; op < 25; op++) begin
            len = $urandom_range(1, MAXD);
            for (int i = 0; i < len; i++) begin
                a = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(3, 12));
                b = 4'($urandom_range(3, 12));
                send_beat(a, b, i == len - 1);
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
        end
        drain();
        rnd_ready = 0;
        @(posedge clk); #1;
        bus.out_ready = 1;
    endtask

    initial begin
        test_reset();
        test_single_zero();
        test_45_78();
        test_9999_0001();
        test_hold();
        test_err();
        test_forced_end();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
